// File: rtl/multi_func_calc_core.sv
// Keypad calculator core: builds decimal operands, runs add/sub/shift-add multiply with chaining.
// Latency: equals strobe to result_valid is 2 cycles for add/sub and WIDTH+1 cycles for multiply.
// Backpressure: busy is high through COMPUTE; keys arriving then are dropped, never queued.
module multi_func_calc_core #(
  parameter int WIDTH      = 8,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic             clk,
  input  logic             clearall,
  input  logic             clearentry,
  input  logic             trig,
  input  logic [3:0]       key_value,
  output logic [WIDTH-1:0] disp_value,
  output logic             disp_neg,
  output logic             ovf,
  output logic             iuau,
  output logic             busy,
  output logic             result_valid,
  output logic [2:0]       state
);
  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0, ST_OP_WAIT = 3'd1, ST_ENTER_B = 3'd2,
    ST_COMPUTE = 3'd3, ST_RESULT  = 3'd4, ST_ERROR   = 3'd5
  } state_t;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2} op_t;

  localparam int               CW       = $clog2(WIDTH);
  localparam logic [WIDTH+3:0] TEN      = (WIDTH+4)'(10);
  localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH-1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  state_t             state_q, state_d;
  op_t                op_q, op_d, nop_q, nop_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
  logic               chain_q, chain_d, neg_q, neg_d, rv_q, rv_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic               key_dig, key_op, key_eq;
  op_t                key_code;
  logic [WIDTH+3:0]   dig_a, dig_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_nx;
  logic               fin, res_neg, res_err, do_clear, start, start_chain;
  logic [WIDTH-1:0]   res;

  // Key decode and arithmetic candidates; wide digit sums expose operand overflow in the top bits
  always_comb begin
    key_dig = (key_value <= 4'd9);
    key_eq  = (key_value == 4'hD);
    key_op  = (key_value == 4'hA) || (key_value == 4'hB) || (ENABLE_MUL && (key_value == 4'hC));
    case (key_value)
      4'hB:    key_code = OP_SUB;
      4'hC:    key_code = OP_MUL;
      default: key_code = OP_ADD;
    endcase
    dig_a  = {4'b0, a_q} * TEN + {{WIDTH{1'b0}}, key_value};
    dig_b  = {4'b0, b_q} * TEN + {{WIDTH{1'b0}}, key_value};
    sum    = {1'b0, a_q} + {1'b0, b_q};
    acc_nx = acc_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);
  end

  // Next-state and datapath updates; clear and compute-start are gathered as flags and applied last
  always_comb begin
    state_d = state_q; op_d = op_q; nop_d = nop_q;
    a_d = a_q; b_d = b_q; r_d = r_q;
    chain_d = chain_q; neg_d = neg_q; rv_d = 1'b0;
    cnt_d = cnt_q; acc_d = acc_q;
    fin = 1'b0; res = '0; res_neg = 1'b0; res_err = 1'b0;
    do_clear = 1'b0; start = 1'b0; start_chain = 1'b0;
    case (state_q)
      ST_COMPUTE: begin
        case (op_q)
          OP_ADD: begin fin = 1'b1; res = sum[WIDTH-1:0]; res_err = sum[WIDTH]; end
          OP_SUB: begin
            fin = 1'b1;
            if (a_q >= b_q) res = a_q - b_q;
            else begin res = b_q - a_q; res_neg = 1'b1; end
          end
          default: begin
            acc_d = acc_nx;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == LAST_BIT) begin
              fin = 1'b1; res = acc_nx[WIDTH-1:0]; res_err = |acc_nx[2*WIDTH-1:WIDTH];
            end
          end
        endcase
        if (fin) begin
          chain_d = 1'b0;
          if (res_err) begin
            state_d = ST_ERROR; neg_d = 1'b0;
          end else begin
            r_d = res; rv_d = 1'b1;
            if (chain_q) begin
              // Chained result becomes the next left operand; magnitude only
              a_d = res; neg_d = 1'b0; op_d = nop_q; state_d = ST_OP_WAIT;
            end else begin
              neg_d = res_neg; state_d = ST_RESULT;
            end
          end
        end
      end
      default: begin
        if (clearentry) begin
          case (state_q)
            ST_ENTER_A:             a_d = '0;
            ST_OP_WAIT, ST_ENTER_B: begin b_d = '0; state_d = ST_OP_WAIT; end
            default:                do_clear = 1'b1;
          endcase
        end else if (trig) begin
          case (state_q)
            ST_ENTER_A: begin
              if (key_dig) begin
                if (dig_a[WIDTH+3:WIDTH] == 4'd0) a_d = dig_a[WIDTH-1:0];
              end else if (key_op) begin
                op_d = key_code; state_d = ST_OP_WAIT;
              end
            end
            ST_OP_WAIT: begin
              if (key_dig) begin
                b_d = {{(WIDTH-4){1'b0}}, key_value}; state_d = ST_ENTER_B;
              end else if (key_op) op_d = key_code;
            end
            ST_ENTER_B: begin
              if (key_dig) begin
                if (dig_b[WIDTH+3:WIDTH] == 4'd0) b_d = dig_b[WIDTH-1:0];
              end else if (key_op) begin
                start = 1'b1; start_chain = 1'b1; nop_d = key_code;
              end else if (key_eq) start = 1'b1;
            end
            ST_RESULT: begin
              if (key_dig) begin
                a_d = {{(WIDTH-4){1'b0}}, key_value}; neg_d = 1'b0; state_d = ST_ENTER_A;
              end else if (key_op && !neg_q) begin
                a_d = r_q; op_d = key_code; state_d = ST_OP_WAIT;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
    if (start) begin
      state_d = ST_COMPUTE; chain_d = start_chain; acc_d = '0; cnt_d = '0;
    end
    if (do_clear) begin
      state_d = ST_ENTER_A; a_d = '0; b_d = '0; r_d = '0;
      op_d = OP_ADD; nop_d = OP_ADD; neg_d = 1'b0; chain_d = 1'b0;
    end
  end

  // State and datapath registers; clearall aborts everything immediately
  always_ff @(posedge clk or posedge clearall) begin
    if (clearall) begin
      state_q <= ST_ENTER_A; op_q <= OP_ADD; nop_q <= OP_ADD;
      a_q <= '0; b_q <= '0; r_q <= '0;
      chain_q <= 1'b0; neg_q <= 1'b0; rv_q <= 1'b0;
      cnt_q <= '0; acc_q <= '0;
    end else begin
      state_q <= state_d; op_q <= op_d; nop_q <= nop_d;
      a_q <= a_d; b_q <= b_d; r_q <= r_d;
      chain_q <= chain_d; neg_q <= neg_d; rv_q <= rv_d;
      cnt_q <= cnt_d; acc_q <= acc_d;
    end
  end

  // Display selection: entry operand while typing, result or blank error afterwards
  always_comb begin
    disp_value = '0;
    iuau       = 1'b0;
    case (state_q)
      ST_ENTER_B: disp_value = b_q;
      ST_RESULT:  begin disp_value = r_q; iuau = 1'b1; end
      ST_ERROR:   iuau = 1'b1;
      default:    disp_value = a_q;
    endcase
  end

  assign disp_neg     = neg_q;
  assign ovf          = (state_q == ST_ERROR);
  assign busy         = (state_q == ST_COMPUTE);
  assign result_valid = rv_q;
  assign state        = state_q;
endmodule
